// File: rtl/dpa_pkg.sv
// dpa_pkg: shared definitions for the DPA pixel engine.
//   - mode codes presented on the engine's mode input
//   - FSM state encoding (also visible on the engine's state_dbg output)
//   - dpa_clog2: constant-function ceil(log2(n)), never returns less than 1
//     so that it can size vectors directly.
package dpa_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_AVG    = 2'b01;
  localparam logic [1:0] MODE_EXPAND = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_EXP  = 2'b10
  } state_t;

  function automatic int dpa_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dpa_ch_acc.sv
// dpa_ch_acc: one colour channel of the AVG datapath.
//   Holds a CW+MAX_LOG2 bit running sum. result is the mean of the stored
//   sum plus the sample currently on 'sample', shifted right by l, so the
//   top level can register it on the same edge that accepts the last sample.
//   Optional macro DPA_PIXEL_ROUND_EN: add 2^(l-1) before the shift
//   (round-half-up, nothing added for l=0); otherwise truncate.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       zero the running sum (wins over add)
//   add         fold 'sample' into the running sum
//   sample      CW-bit channel value of the current input pixel
//   l           log2 of the sample count for this unit
//   result      CW-bit mean (combinational)
module dpa_ch_acc #(
  parameter int CW       = 8,
  parameter int MAX_LOG2 = 4,
  parameter int LW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          add,
  input  logic [CW-1:0] sample,
  input  logic [LW-1:0] l,
  output logic [CW-1:0] result
);

  localparam int AW = CW + MAX_LOG2;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] sum;
  logic [AW-1:0] rnd;
  logic [AW-1:0] shifted;

  assign sum = acc_q + AW'(sample);

`ifdef DPA_PIXEL_ROUND_EN
  assign rnd = (l == '0) ? '0 : (AW'(1) << (l - LW'(1)));
`else
  assign rnd = '0;
`endif

  // 2^l samples of at most 2^CW-1 plus 2^(l-1) stays below 2^(CW+l), so
  // neither the add nor the shifted result can overflow.
  assign shifted = (sum + rnd) >> l;
  assign result  = shifted[CW-1:0];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (add) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/dpa_pixel_engine.sv
// dpa_pixel_engine: NCH x CW pixel operator between the image-memory read
// port and the frame-buffer write register.
//   BYPASS (00, and 11): pixel passes through with one cycle latency.
//   AVG    (01): mean of 2^L pixels per channel, L = clamp(avg_log2).
//   EXPAND (10): low EXP_BITS of one word become EXP_BITS pixels, MSB
//                first, all-ones for a 1 bit and all-zeros for a 0 bit.
// Optional macro DPA_PIXEL_ROUND_EN: AVG rounds half-up instead of truncating.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mode, avg_log2        operation select, sampled on a unit's first input
//   flush                 synchronous abort of the current unit
//   in_valid/in_ready     input handshake, in_data channel k = [k*CW +: CW]
//   out_valid/out_ready   output handshake, out_data registered
//   busy                  high in ACC or EXP
//   state_dbg             current FSM state (dpa_pkg::state_t encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_valid/out_data are registered and held while stalled;
// in_ready = !out_valid | out_ready outside EXP, 0 in EXP, and 0 during
// reset or flush.
module dpa_pixel_engine
  import dpa_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int CW       = 8,
  parameter int MAX_LOG2 = 4,
  parameter int EXP_BITS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          mode,
  input  logic [dpa_clog2(MAX_LOG2+1)-1:0]    avg_log2,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NCH*CW-1:0]                   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NCH*CW-1:0]                   out_data,
  output logic                                busy,
  output logic [1:0]                          state_dbg
);

  localparam int LW   = dpa_clog2(MAX_LOG2 + 1);
  localparam int BW   = dpa_clog2(EXP_BITS);
  localparam int CNTW = MAX_LOG2 + 1;
  localparam int DW   = NCH * CW;

  state_t              state_q, state_d;
  logic [LW-1:0]       l_q, l_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [EXP_BITS-1:0] word_q, word_d;
  logic                out_valid_d;
  logic [DW-1:0]       out_data_d;
  logic                acc_clear, acc_add;
  logic [LW-1:0]       l_in;
  logic [CNTW-1:0]     last_cnt;
  logic [BW-1:0]       bit_nx;
  logic [DW-1:0]       avg_result;
  logic                in_fire, out_fire;

  assign l_in      = (avg_log2 > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : avg_log2;
  // Count of samples already held when the unit's final sample arrives.
  assign last_cnt  = (CNTW'(1) << l_q) - CNTW'(1);
  assign bit_nx    = bit_q - BW'(1);

  assign in_ready  = !reset && !flush && (state_q != ST_EXP) &&
                     (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state_q == ST_ACC) || (state_q == ST_EXP);
  assign state_dbg = state_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    dpa_ch_acc #(
      .CW       (CW),
      .MAX_LOG2 (MAX_LOG2),
      .LW       (LW)
    ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clear  (acc_clear),
      .add    (acc_add),
      .sample (in_data[k*CW +: CW]),
      .l      (l_q),
      .result (avg_result[k*CW +: CW])
    );
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    word_d      = word_q;
    out_valid_d = out_fire ? 1'b0 : out_valid;
    out_data_d  = out_data;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;

    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      bit_d       = '0;
      out_valid_d = 1'b0;
      acc_clear   = 1'b0 | 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            l_d = l_in;
            if (mode == MODE_AVG && l_in != '0) begin
              acc_add = 1'b1;
              cnt_d   = CNTW'(1);
              state_d = ST_ACC;
            end else if (mode == MODE_EXPAND) begin
              word_d      = in_data[EXP_BITS-1:0];
              bit_d       = BW'(EXP_BITS - 1);
              state_d     = ST_EXP;
              out_valid_d = 1'b1;
              out_data_d  = {DW{in_data[EXP_BITS-1]}};
            end else begin
              // BYPASS, code 11, and AVG with L=0
              out_valid_d = 1'b1;
              out_data_d  = in_data;
            end
          end
        end
        ST_ACC: begin
          if (in_fire) begin
            if (cnt_q == last_cnt) begin
              out_valid_d = 1'b1;
              out_data_d  = avg_result;
              acc_clear   = 1'b1;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end else begin
              acc_add = 1'b1;
              cnt_d   = cnt_q + CNTW'(1);
            end
          end
        end
        ST_EXP: begin
          if (out_fire) begin
            if (bit_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              bit_d       = bit_nx;
              out_valid_d = 1'b1;
              out_data_d  = {DW{word_q[bit_nx]}};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      l_q       <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_dpa_pixel_engine.sv
// tb_dpa_pixel_engine: directed test-plan steps followed by a randomized
// phase checked against a transaction-level reference model.
module tb_dpa_pixel_engine;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  avg_log2;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_errors;

  // reference model state
  logic [23:0] exp_q[$];
  int          exp_left;
  bit          avg_active;
  int          avg_l;
  int          avg_n;
  int          sums[3];

`ifdef DPA_PIXEL_ROUND_EN
  localparam logic [23:0] AVG_L2_RESULT = 24'd26;
`else
  localparam logic [23:0] AVG_L2_RESULT = 24'd25;
`endif

  dpa_pixel_engine u_dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .avg_log2  (avg_log2),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // one clock: inputs change and outputs are observed at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mean of the collected samples, per channel, by plain division
  function automatic logic [23:0] avg_pixel(input int l);
    logic [23:0] r;
    int div;
    int v;
    r = '0;
    div = 1 << l;
    for (int k = 0; k < 3; k++) begin
      v = sums[k];
`ifdef DPA_PIXEL_ROUND_EN
      if (l > 0) v = v + div / 2;
`endif
      r[k*8 +: 8] = 8'(v / div);
    end
    return r;
  endfunction

  task automatic model_accept(input logic [1:0] m, input int l_raw, input logic [23:0] d);
    int l;
    l = (l_raw > 4) ? 4 : l_raw;
    if (avg_active) begin
      for (int k = 0; k < 3; k++) sums[k] += int'(d[k*8 +: 8]);
      avg_n++;
      if (avg_n == (1 << avg_l)) begin
        exp_q.push_back(avg_pixel(avg_l));
        avg_active = 1'b0;
      end
    end else if (m == 2'b01 && l > 0) begin
      avg_active = 1'b1;
      avg_l = l;
      avg_n = 1;
      for (int k = 0; k < 3; k++) sums[k] = int'(d[k*8 +: 8]);
    end else if (m == 2'b10) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back(d[b] ? 24'hFFFFFF : 24'h000000);
      exp_left = 8;
    end else begin
      exp_q.push_back(d);
    end
  endtask

  task automatic rand_cycle(input bit drain);
    logic [23:0] want;
    if (drain) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end else begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 24'($urandom);
      mode      = 2'($urandom_range(0, 3));
      avg_log2  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    #1;
    if (exp_left > 0) chk("rnd_exp_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      chk("rnd_out_expected", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("rnd_out_data", out_data, want);
      end
      if (exp_left > 0) exp_left--;
    end
    if (in_valid && in_ready) model_accept(mode, int'(avg_log2), in_data);
    step();
  endtask

  initial begin
    logic [7:0] word;
    n_checks = 0;
    n_errors = 0;
    exp_left = 0;
    avg_active = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    mode = 2'b00; avg_log2 = '0; out_ready = 1'b1;

    // reset state
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);

    // BYPASS back-to-back
    mode = 2'b00; in_valid = 1'b1; in_data = 24'h123456;
    step();
    chk("byp_valid0", out_valid, 1);
    chk("byp_out0", out_data, 24'h123456);
    chk("byp_in_ready", in_ready, 1);
    in_data = 24'hABCDEF;
    step();
    chk("byp_out1", out_data, 24'hABCDEF);
    in_valid = 1'b0;
    step();
    chk("byp_drained", out_valid, 0);

    // AVG L=2, mode/avg_log2 changes mid-unit must be ignored
    mode = 2'b01; avg_log2 = 3'd2; in_valid = 1'b1; in_data = 24'd10;
    step();
    chk("avg2_busy1", busy, 1);
    chk("avg2_noout1", out_valid, 0);
    mode = 2'b10; avg_log2 = 3'd0; in_data = 24'd20;
    step();
    chk("avg2_busy2", busy, 1);
    in_data = 24'd30;
    step();
    chk("avg2_busy3", busy, 1);
    chk("avg2_noout3", out_valid, 0);
    in_data = 24'd42;
    step();
    chk("avg2_valid", out_valid, 1);
    chk("avg2_out", out_data, AVG_L2_RESULT);
    chk("avg2_idle", busy, 0);
    in_valid = 1'b0;
    step();
    chk("avg2_drained", out_valid, 0);

    // AVG L=1 at full scale
    mode = 2'b01; avg_log2 = 3'd1; in_valid = 1'b1; in_data = 24'hFFFFFF;
    step(); step();
    in_valid = 1'b0;
    chk("avg1_valid", out_valid, 1);
    chk("avg1_out", out_data, 24'hFFFFFF);
    step();

    // EXPAND of 0xA5 (upper bits must be ignored)
    mode = 2'b10; in_valid = 1'b1; in_data = 24'h3C00A5;
    word = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      chk("exp_valid", out_valid, 1);
      chk("exp_pixel", out_data, word[b] ? 24'hFFFFFF : 24'h000000);
      chk("exp_in_ready", in_ready, 0);
      step();
    end
    chk("exp_done_valid", out_valid, 0);
    chk("exp_done_in_ready", in_ready, 1);
    chk("exp_done_busy", busy, 0);

    // back-pressure
    mode = 2'b00; out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h111111;
    step();
    in_data = 24'h222222;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, 24'h111111);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_out", out_data, 24'h222222);
    step();

    // flush after two AVG samples, then a clean unit of four 8s
    mode = 2'b01; avg_log2 = 3'd2; in_valid = 1'b1; in_data = 24'd100;
    step(); step();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 24'h080808;
    repeat (4) step();
    in_valid = 1'b0;
    chk("flush_avg_valid", out_valid, 1);
    chk("flush_avg_out", out_data, 24'h080808);
    step();

    // reset in the middle of EXPAND
    mode = 2'b10; in_valid = 1'b1; in_data = 24'h0000FF;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("rexp_busy", busy, 1);
    reset = 1'b1;
    step();
    chk("rexp_valid", out_valid, 0);
    chk("rexp_state", state_dbg, 0);
    chk("rexp_data", out_data, 0);
    reset = 1'b0; out_ready = 1'b1;
    step();

    // randomized traffic against the reference model
    exp_q.delete();
    exp_left = 0;
    avg_active = 1'b0;
    for (int i = 0; i < 600; i++) rand_cycle(1'b0);
    for (int i = 0; i < 40; i++) rand_cycle(1'b1);
    chk("rnd_all_outputs_seen", exp_q.size(), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    avg_active = 1'b0;
    chk("rnd_final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
